fetch_pc_unit: RTL

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/mips_pkg.sv | 24 ++
 rtl/pc_next_calc.sv | 66 ++++++
 rtl/fetch_pc_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch front end.
//
// Contents:
//   fetch_state_e    - state of the fetch-PC state machine (BOOT / RUN / HALTED)
//   pc_sel_e         - which source feeds the next PC (SEQ / BR / J / JR)
//   RESET_PC_DEFAULT - default first fetch address after reset
package mips_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } pc_sel_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC calculator.
//
// Picks the candidate next fetch address from the current PC and the redirect
// requests. Priority is jr > j > taken branch > sequential. All arithmetic is
// 32-bit and wraps silently.
//
// Ports:
//   pc            in   current fetch address
//   branch_taken  in   PC-relative branch requested
//   branch_offset in   signed word offset (immediate field)
//   jump          in   J-type jump requested
//   jump_target   in   26-bit J-type target field
//   jump_reg      in   register jump (jr) requested
//   reg_target    in   register jump address
//   pc_plus4      out  pc + 4
//   next_pc       out  selected candidate next PC
module pc_next_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    pc_sel_e     sel;
    logic [31:0] branch_disp;
    logic [31:0] branch_pc;
    logic [31:0] jump_pc;

    assign pc_plus4 = pc + 32'd4;

    // Word offset sign-extended and converted to a byte displacement.
    assign branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign branch_pc   = pc_plus4 + branch_disp;

    // J-type keeps the 256 MB region of the delay-slot address.
    assign jump_pc     = {pc_plus4[31:28], jump_target, 2'b00};

    always_comb begin
        sel = SEL_SEQ;
        if (jump_reg) begin
            sel = SEL_JR;
        end else if (jump) begin
            sel = SEL_J;
        end else if (branch_taken) begin
            sel = SEL_BR;
        end
    end

    always_comb begin
        next_pc = pc_plus4;
        case (sel)
            SEL_JR:  next_pc = reg_target;
            SEL_J:   next_pc = jump_pc;
            SEL_BR:  next_pc = branch_pc;
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch program-counter unit.
//
// Holds the PC register and a small BOOT/RUN/HALTED state machine. After reset
// release the unit spends one BOOT cycle, then fetches sequentially or follows
// redirects. A misaligned or out-of-range next PC freezes the PC and halts the
// unit until the next reset; a misaligned target also sets the sticky
// misalign_err flag.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   stall          hold the PC this cycle (overrides and drops any redirect)
//   branch_taken   take PC-relative branch, offset in branch_offset
//   jump           take J-type jump, target field in jump_target
//   jump_reg       take register jump to reg_target
//   pc             current fetch address
//   pc_plus4       pc + 4 for the link path
//   fetch_valid    pc is a legal fetch this cycle
//   halted         sticky stop indication
//   misalign_err   sticky misaligned-target flag
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_WORDS = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        halted,
    output logic        misalign_err
);

    // First byte address past the end of instruction memory.
    localparam logic [31:0] IMEM_LIMIT = 32'(4 * IMEM_WORDS);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         misalign_q, misalign_d;
    logic [31:0]  next_pc;

    pc_next_calc u_pc_next_calc (
        .pc            (pc_q),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .jump_reg      (jump_reg),
        .reg_target    (reg_target),
        .pc_plus4      (pc_plus4),
        .next_pc       (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    // A bad target never reaches the PC register: the PC keeps the last good
    // address and the unit halts. Misalignment is checked first so it is
    // flagged even when the target is also out of range.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!stall) begin
                    if (next_pc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = ST_HALTED;
                    end else if (next_pc >= IMEM_LIMIT) begin
                        state_d    = ST_HALTED;
                    end else begin
                        pc_d       = next_pc;
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign pc           = pc_q;
    assign fetch_valid  = (state_q == ST_RUN);
    assign halted       = (state_q == ST_HALTED);
    assign misalign_err = misalign_q;

endmodule
